// File: rtl/prog_counter.sv
// Programmable up/down counter with run-time terminal value, saturate/wrap mode,
// parallel load and a registered one-cycle wrap pulse.
module prog_counter #(
  parameter int              WIDTH     = 9,
  parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}},
  parameter logic            MODE_RST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setZ,
  input  logic             run,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_val,
  input  logic             mode_wr,
  input  logic             mode_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             flag,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic             mode_reg, mode_next;
  logic             wrap_reg, wrap_next;

  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic [WIDTH-1:0] load_clamped;

  // One run step in the current direction. Increment/decrement are only selected
  // when they cannot overflow, so no carry/borrow handling is needed.
  always_comb begin
    step_val  = count_reg;
    step_wrap = 1'b0;
    if (!dir) begin
      if (count_reg < limit_reg) begin
        step_val = count_reg + ONE;
      end else if (mode_reg) begin
        step_val  = ZERO;
        step_wrap = 1'b1;
      end else begin
        step_val = limit_reg;
      end
    end else begin
      if (count_reg > limit_reg) begin
        step_val = limit_reg;
      end else if (count_reg != ZERO) begin
        step_val = count_reg - ONE;
      end else if (mode_reg) begin
        step_val  = limit_reg;
        step_wrap = 1'b1;
      end else begin
        step_val = ZERO;
      end
    end
  end

  assign load_clamped = (load_val > limit_reg) ? limit_reg : load_val;

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (setZ) begin
      count_next = ZERO;
    end else if (load) begin
      count_next = load_clamped;
    end else if (run) begin
      count_next = step_val;
      wrap_next  = step_wrap;
    end
  end

  // Limit and mode writes sit outside the count priority chain; they only take
  // effect for the following cycle.
  always_comb begin
    limit_next = limit_wr ? limit_val : limit_reg;
    mode_next  = mode_wr ? mode_val : mode_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= ZERO;
      limit_reg <= LIMIT_RST;
      mode_reg  <= MODE_RST;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      limit_reg <= limit_next;
      mode_reg  <= mode_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count      = count_reg;
  assign limit      = limit_reg;
  assign wrap_pulse = wrap_reg;
  assign flag       = dir ? (count_reg == ZERO) : (count_reg >= limit_reg);

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a behavioural model.
module tb_prog_counter;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst, setZ, run, dir, load, limit_wr, mode_wr, mode_val;
  logic [W-1:0] load_val, limit_val;
  logic [W-1:0] count, limit;
  logic         flag, wrap_pulse;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;
  bit verbose = 1'b1;

  // Behavioural model state
  int m_count, m_limit, m_mode, m_wrap;

  prog_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .setZ(setZ), .run(run), .dir(dir),
    .load(load), .load_val(load_val), .limit_wr(limit_wr), .limit_val(limit_val),
    .mode_wr(mode_wr), .mode_val(mode_val),
    .count(count), .limit(limit), .flag(flag), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: applies the counter rules directly to integers at each rising edge.
  always @(posedge clk) begin
    int nc, nw;
    if (rst) begin
      m_count = 0; m_limit = (1 << W) - 1; m_mode = 0; m_wrap = 0;
    end else begin
      nc = m_count;
      nw = 0;
      if (setZ) nc = 0;
      else if (load) nc = (int'(load_val) < m_limit) ? int'(load_val) : m_limit;
      else if (run) begin
        if (!dir) begin
          if (m_count < m_limit) nc = m_count + 1;
          else if (m_mode == 1) begin nc = 0; nw = 1; end
          else nc = m_limit;
        end else begin
          if (m_count > m_limit) nc = m_limit;
          else if (m_count > 0) nc = m_count - 1;
          else if (m_mode == 1) begin nc = m_limit; nw = 1; end
          else nc = 0;
        end
      end
      if (limit_wr) m_limit = int'(limit_val);
      if (mode_wr) m_mode = int'(mode_val);
      m_count = nc;
      m_wrap = nw;
    end
  end

  // Compare process: checks all outputs mid-cycle, inputs stable.
  always @(negedge clk) begin
    if (compare_on) begin
      check("cmp_count", 32'(count), 32'(m_count));
      check("cmp_limit", 32'(limit), 32'(m_limit));
      check("cmp_wrap", 32'(wrap_pulse), 32'(m_wrap));
      check("cmp_flag", 32'(flag), (dir ? (m_count == 0) : (m_count >= m_limit)) ? 32'd1 : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (verbose)
      $display("txn t=%0t count=%0d limit=%0d flag=%0d wrap=%0d", $time, count, limit, flag, wrap_pulse);
  endtask

  task automatic idle();
    rst = 0; setZ = 0; run = 0; load = 0; limit_wr = 0; mode_wr = 0;
  endtask

  initial begin
    int exp_seq[$];
    int exp_wrap[$];
    idle();
    dir = 0; load_val = '0; limit_val = '0; mode_val = 0;
    rst = 1;
    cyc();
    rst = 0;
    compare_on = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_limit", 32'(limit), 32'd511);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);

    // 1: saturating count up to default limit
    verbose = 1'b0;
    run = 1;
    for (int i = 1; i <= 520; i++) begin
      cyc();
      check("t1_count", 32'(count), (i < 511) ? 32'(i) : 32'd511);
      check("t1_flag", 32'(flag), (i >= 511) ? 32'd1 : 32'd0);
      check("t1_wrap", 32'(wrap_pulse), 32'd0);
    end
    verbose = 1'b1;

    // 2: wrap up with limit 5
    idle();
    mode_wr = 1; mode_val = 1; limit_wr = 1; limit_val = 5; setZ = 1;
    cyc();
    idle();
    check("t2_start", 32'(count), 32'd0);
    run = 1;
    exp_seq = '{1, 2, 3, 4, 5, 0, 1};
    exp_wrap = '{0, 0, 0, 0, 0, 1, 0};
    foreach (exp_seq[k]) begin
      cyc();
      check("t2_count", 32'(count), 32'(exp_seq[k]));
      check("t2_wrap", 32'(wrap_pulse), 32'(exp_wrap[k]));
      check("t2_flag", 32'(flag), (exp_seq[k] == 5) ? 32'd1 : 32'd0);
    end

    // 3a: down wrap
    idle();
    dir = 1; load = 1; load_val = 2;
    cyc();
    idle();
    check("t3_load", 32'(count), 32'd2);
    run = 1;
    exp_seq = '{1, 0, 5, 4};
    exp_wrap = '{0, 0, 1, 0};
    foreach (exp_seq[k]) begin
      cyc();
      check("t3a_count", 32'(count), 32'(exp_seq[k]));
      check("t3a_wrap", 32'(wrap_pulse), 32'(exp_wrap[k]));
    end
    // 3b: down saturate
    idle();
    mode_wr = 1; mode_val = 0; load = 1; load_val = 2;
    cyc();
    idle();
    run = 1;
    exp_seq = '{1, 0, 0, 0};
    foreach (exp_seq[k]) begin
      cyc();
      check("t3b_count", 32'(count), 32'(exp_seq[k]));
      check("t3b_wrap", 32'(wrap_pulse), 32'd0);
      check("t3b_flag", 32'(flag), (exp_seq[k] == 0) ? 32'd1 : 32'd0);
    end

    // 4: priority and same-cycle limit write
    idle();
    dir = 0; load = 1; load_val = 3;
    cyc();
    check("t4_load3", 32'(count), 32'd3);
    setZ = 1; load = 1; load_val = 7; run = 1;
    cyc();
    check("t4_setz_wins", 32'(count), 32'd0);
    setZ = 0;
    cyc();
    check("t4_load_clamp", 32'(count), 32'd5);
    idle();
    load = 1; load_val = 4;
    cyc();
    idle();
    run = 1; limit_wr = 1; limit_val = 2;
    cyc();
    check("t4_old_limit", 32'(count), 32'd5);
    check("t4_new_limit", 32'(limit), 32'd2);
    limit_wr = 0;
    cyc();
    check("t4_clamp_down", 32'(count), 32'd2);

    // 5: reset mid-operation
    idle();
    mode_wr = 1; mode_val = 1; limit_wr = 1; limit_val = 3; setZ = 1;
    cyc();
    idle();
    run = 1;
    cyc();
    cyc();
    check("t5_pre", 32'(count), 32'd2);
    rst = 1;
    cyc();
    rst = 0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_limit", 32'(limit), 32'd511);
    check("t5_wrap", 32'(wrap_pulse), 32'd0);
    cyc();
    check("t5_after", 32'(count), 32'd1);

    // 6: limit 0 continuous wrap
    idle();
    limit_wr = 1; limit_val = 0; mode_wr = 1; mode_val = 1; setZ = 1;
    cyc();
    idle();
    run = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t6_count", 32'(count), 32'd0);
      check("t6_wrap", 32'(wrap_pulse), 32'd1);
      check("t6_flag", 32'(flag), 32'd1);
    end

    // Randomized traffic, checked by the compare process
    verbose = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      setZ     = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      run      = ($urandom_range(0, 3) != 0);
      dir      = ($urandom_range(0, 3) == 0) ? ~dir : dir;
      load_val = W'($urandom_range(0, 511));
      limit_wr = ($urandom_range(0, 15) == 0);
      limit_val = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 8)) : W'($urandom_range(0, 511));
      mode_wr  = ($urandom_range(0, 15) == 0);
      mode_val = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
